spi_master_cfg: RTL and testbench

Parametrised SPI master that generates its own SCLK from clk via an integer divider. Supports all four CPOL/CPHA modes, selected per transfer, and configurable word width. Drives one of NUM_SS active-low slave selects. Sits between on-chip control logic (start/busy/done handshake) and external SPI peripherals such as ADCs, DACs and LED drivers. It replaces the fixed 16-bit, externally clocked, mode-0-only master.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 34 +++
 rtl/spi_master_cfg.sv | 170 +++++++++++++++++
 tb/tb_spi_master_cfg.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master.
//   spi_state_e : transfer sequencer states
//   CPOL_BIT/CPHA_BIT : bit positions inside the 2-bit mode word {CPOL,CPHA}
//   div_w()     : width of a counter that must hold CLK_DIV-1
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

    // At least one bit so CLK_DIV=1 and CLK_DIV=2 still get a legal counter.
    function automatic int unsigned div_w(input int unsigned div);
        return (div > 2) ? int'($clog2(div)) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for SCLK generation.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : reload the counter to DIV-1 (held while not shifting)
//   en       : count down one step per clk
//   tick_c   : combinational one-cycle strobe when the count reaches zero
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned DIV_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick_c
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    // Down-counter reloads on every strobe so strobes are DIV clk cycles apart.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - DIV_W'(1);
        end
    end

    assign tick_c = en && (cnt == '0);

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with internal SCLK divider, per-transfer CPOL/CPHA and
// parametrised word width, MSB first.
//   clk, rst          : system clock, synchronous active-high reset
//   start             : transfer request, accepted only while busy=0
//   tx_data/ss_sel/mode : word, slave index and {CPOL,CPHA}, latched on accept
//   busy, done        : in-progress flag and one-cycle completion pulse
//   rx_data           : received word, updated on the done cycle
//   miso, mosi, sclk, ss_n : SPI bus (ss_n active low, one bit per slave)
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_W   = 16,
    parameter  int unsigned CLK_DIV  = 4,
    parameter  int unsigned NUM_SS   = 1,
    localparam int unsigned SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [SS_IDX_W-1:0] ss_sel,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rx_data,
    input  logic                miso,
    output logic                mosi,
    output logic                sclk,
    output logic [NUM_SS-1:0]   ss_n
);

    localparam int unsigned      DIV_W   = div_w(CLK_DIV);
    localparam int unsigned      CNT_W   = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0] PH_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(2 * DATA_W - 1);

    spi_state_e          state, state_d;
    logic [DATA_W-1:0]   tx_sh, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh, rx_sh_d;
    logic [1:0]          mode_q, mode_d;
    logic [SS_IDX_W-1:0] sel_q, sel_d;
    logic [DIV_W-1:0]    ph, ph_d;
    logic [CNT_W-1:0]    ecnt, ecnt_d;
    logic                busy_d, done_d, mosi_d, sclk_d;
    logic [DATA_W-1:0]   rx_data_d;
    logic [NUM_SS-1:0]   ss_n_d;
    logic                tick_c, sample, shift;

    spi_clk_div #(
        .DIV   (CLK_DIV),
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != XFER),
        .en     (state == XFER),
        .tick_c (tick_c)
    );

    // Register bank: sequencer state plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            mode_q  <= '0;
            sel_q   <= '0;
            ph      <= '0;
            ecnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            mosi    <= 1'b0;
            sclk    <= 1'b0;
            ss_n    <= '1;
        end else begin
            state   <= state_d;
            tx_sh   <= tx_sh_d;
            rx_sh   <= rx_sh_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            ph      <= ph_d;
            ecnt    <= ecnt_d;
            busy    <= busy_d;
            done    <= done_d;
            rx_data <= rx_data_d;
            mosi    <= mosi_d;
            sclk    <= sclk_d;
            ss_n    <= ss_n_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        tx_sh_d   = tx_sh;
        rx_sh_d   = rx_sh;
        mode_d    = mode_q;
        sel_d     = sel_q;
        ph_d      = ph;
        ecnt_d    = ecnt;
        sclk_d    = sclk;
        done_d    = 1'b0;
        rx_data_d = rx_data;
        sample    = 1'b0;
        shift     = 1'b0;

        unique case (state)
            IDLE: begin
                sclk_d = mode_q[CPOL_BIT];
                if (start) begin
                    state_d = LEAD;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    mode_d  = mode;
                    sel_d   = ss_sel;
                    ph_d    = PH_LOAD;
                    sclk_d  = mode[CPOL_BIT];
                end
            end
            LEAD: begin
                if (ph == '0) begin
                    state_d = XFER;
                    ecnt_d  = '0;
                end else begin
                    ph_d = ph - DIV_W'(1);
                end
            end
            XFER: begin
                if (tick_c) begin
                    sclk_d = ~sclk;
                    // ecnt counts strobes already taken, so ecnt[0]==0 marks an odd strobe.
                    if (mode_q[CPHA_BIT]) begin
                        sample = ecnt[0];
                        shift  = !ecnt[0] && (ecnt != '0);
                    end else begin
                        sample = !ecnt[0];
                        shift  = ecnt[0] && (ecnt != LAST);
                    end
                    if (sample) rx_sh_d = {rx_sh[DATA_W-2:0], miso};
                    if (shift)  tx_sh_d = {tx_sh[DATA_W-2:0], 1'b0};
                    if (ecnt == LAST) begin
                        state_d = TRAIL;
                        ph_d    = PH_LOAD;
                    end else begin
                        ecnt_d = ecnt + CNT_W'(1);
                    end
                end
            end
            TRAIL: begin
                if (ph == '0) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh;
                end else begin
                    ph_d = ph - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        mosi_d = busy_d & tx_sh_d[DATA_W-1];
        // An out-of-range index simply matches no bit.
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = !(busy_d && (sel_d == SS_IDX_W'(i)));
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg, two configurations side by side:
//   cfg0: DATA_W=16, CLK_DIV=2, NUM_SS=3   cfg1: DATA_W=8, CLK_DIV=1, NUM_SS=1
// Each has a protocol-level SPI slave, a stimulus driver that pushes expected
// results, and a monitor that pops and compares on every done pulse.
module tb_spi_master_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rx;
        logic [31:0] tx;
        int          sel;
        logic [1:0]  mode;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_ssn(input int sel, input int ns);
        logic [7:0] r;
        r = '1;
        for (int i = 0; i < ns; i++) if (i == sel) r[i] = 1'b0;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_cfg
        localparam int unsigned DW = (g == 0) ? 16 : 8;
        localparam int unsigned CD = (g == 0) ? 2 : 1;
        localparam int unsigned NS = (g == 0) ? 3 : 1;
        localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
        localparam logic [31:0] MASK = 32'((64'd1 << DW) - 64'd1);
        localparam logic [NS-1:0] SS_OFF = '1;

        logic          rst, start, busy, done, miso, mosi, sclk;
        logic [DW-1:0] tx_data, rx_data;
        logic [SW-1:0] ss_sel;
        logic [1:0]    mode;
        logic [NS-1:0] ss_n;
        logic [31:0]   sl_word, sl_rx;
        logic [1:0]    sl_mode;
        logic          last_cpol;
        bit            fin = 1'b0;
        exp_t          q[$];

        spi_master_cfg #(
            .DATA_W  (DW),
            .CLK_DIV (CD),
            .NUM_SS  (NS)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .tx_data (tx_data),
            .ss_sel  (ss_sel),
            .mode    (mode),
            .busy    (busy),
            .done    (done),
            .rx_data (rx_data),
            .miso    (miso),
            .mosi    (mosi),
            .sclk    (sclk),
            .ss_n    (ss_n)
        );

        task automatic c(input string name, input logic [31:0] act, input logic [31:0] exp);
            chk($sformatf("cfg%0d %s", g, name), act, exp);
        endtask

        // SPI slave: shifts out sl_word and collects what it receives, per CPOL/CPHA.
        initial begin : slave
            logic [31:0] word, rxw;
            logic        pol, pha, lead;
            int          idx;
            miso  = 1'b0;
            sl_rx = '0;
            forever begin
                wait (!(&ss_n));
                word = sl_word;
                pol  = sl_mode[1];
                pha  = sl_mode[0];
                idx  = int'(DW) - 1;
                rxw  = '0;
                if (!pha) miso = word[idx];
                while (!(&ss_n)) begin
                    @(sclk or ss_n);
                    if (&ss_n) break;
                    lead = (sclk != pol);
                    if (lead == !pha) begin
                        rxw = {rxw[30:0], mosi};
                    end else if (lead) begin
                        if (idx >= 0) miso = word[idx];
                        idx--;
                    end else begin
                        idx--;
                        if (idx >= 0) miso = word[idx];
                    end
                end
                sl_rx = rxw;
                miso  = 1'b0;
            end
        end

        // Monitor: accumulates per-transfer observations, compares on done.
        initial begin : monitor
            int            blen, tog;
            logic          prev_sclk;
            bit            ss_bad, hold_bad;
            logic [DW-1:0] rx_prev;
            logic [7:0]    es;
            exp_t          e;
            blen = 0; tog = 0; ss_bad = 0; hold_bad = 0;
            prev_sclk = 1'b0; rx_prev = '0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    blen = 0; tog = 0; ss_bad = 0; hold_bad = 0;
                    prev_sclk = sclk; rx_prev = rx_data;
                    continue;
                end
                if (!done && rx_data !== rx_prev) hold_bad = 1;
                if (busy) begin
                    if (blen > 0 && sclk !== prev_sclk) tog++;
                    if (blen == 0 && q.size() > 0) c("lead_sclk", 32'(sclk), 32'(q[0].mode[1]));
                    es = (q.size() > 0) ? exp_ssn(q[0].sel, int'(NS)) : 8'hFF;
                    if (ss_n !== es[NS-1:0]) ss_bad = 1;
                    blen++;
                end else if (ss_n !== SS_OFF) begin
                    ss_bad = 1;
                end
                prev_sclk = sclk;
                rx_prev   = rx_data;
                if (done) begin
                    if (q.size() == 0) begin
                        c("spurious_done", 32'(done), 32'(0));
                    end else begin
                        e = q.pop_front();
                        c("busy_at_done", 32'(busy), 32'(0));
                        c("busy_len", 32'(blen), 32'(CD * (2 * DW + 2)));
                        c("sclk_edges", 32'(tog), 32'(2 * DW));
                        c("rx_data", 32'(rx_data), e.rx);
                        if (e.sel < int'(NS)) c("slave_rx", sl_rx & MASK, e.tx);
                        c("sclk_idle", 32'(sclk), 32'(e.mode[1]));
                        c("ss_n_done", 32'(ss_n), 32'(SS_OFF));
                        c("ss_n_pattern_ok", 32'(ss_bad), 32'(0));
                        c("rx_hold_ok", 32'(hold_bad), 32'(0));
                    end
                    blen = 0; tog = 0; ss_bad = 0; hold_bad = 0;
                end
            end
        end

        // Waits for idle (the done cycle counts), then issues one transfer.
        task automatic issue(input logic [31:0] w, input int sel, input logic [1:0] m,
                             input logic [31:0] sw, input int gap);
            int   n;
            exp_t e;
            n = 0;
            @(negedge clk);
            while (busy === 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            c("idle_wait", 32'(busy), 32'(0));
            repeat (gap) @(negedge clk);
            c("sclk_before", 32'(sclk), 32'(last_cpol));
            tx_data = DW'(w);
            ss_sel  = SW'(sel);
            mode    = m;
            sl_word = sw;
            sl_mode = m;
            e.tx    = w & MASK;
            e.rx    = (sel < int'(NS)) ? (sw & MASK) : 32'd0;
            e.sel   = sel;
            e.mode  = m;
            q.push_back(e);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            c("busy_rise", 32'(busy), 32'(1));
            tx_data   = DW'($urandom);
            mode      = 2'($urandom);
            ss_sel    = SW'($urandom);
            last_cpol = m[1];
        endtask

        initial begin : driver
            int   n, tg;
            logic ps;
            rst = 1'b1; start = 1'b0; tx_data = '0; ss_sel = '0; mode = '0;
            sl_word = '0; sl_mode = '0; last_cpol = 1'b0;
            repeat (3) @(negedge clk);
            c("rst_busy", 32'(busy), 32'(0));
            c("rst_done", 32'(done), 32'(0));
            c("rst_rx_data", 32'(rx_data), 32'(0));
            c("rst_mosi", 32'(mosi), 32'(0));
            c("rst_sclk", 32'(sclk), 32'(0));
            c("rst_ss_n", 32'(ss_n), 32'(SS_OFF));
            rst = 1'b0;

            issue(32'hA5C3, 0, 2'd0, 32'hA5C3, 1);
            issue(32'hBEEF, 0, 2'd3, 32'h1234, 2);
            issue(32'h00C3, int'(NS) - 1, 2'd3, 32'h005A, 0);
            issue(32'h003C, 0, 2'd1, 32'h005A, 3);
            issue(32'h00A6, 0, 2'd2, 32'h005A, 0);
            issue($urandom, int'(NS), 2'd0, $urandom, 1);

            // start while busy must be ignored
            issue(32'h1357, int'(NS) - 1, 2'd2, 32'h2468, 1);
            repeat (3) @(negedge clk);
            start = 1'b1; tx_data = '1; mode = 2'd1; ss_sel = '0;
            @(negedge clk);
            start = 1'b0;

            for (int i = 0; i < 16; i++) begin
                issue($urandom, int'($urandom_range(0, NS)), 2'($urandom), $urandom,
                      int'($urandom_range(0, 2)));
            end

            // reset after 10 SCLK strobes aborts the transfer silently
            issue($urandom, 0, 2'($urandom), $urandom, 2);
            n = 0; tg = 0; ps = sclk;
            while (tg < 10 && n < 1000) begin
                @(negedge clk);
                if (sclk !== ps) tg++;
                ps = sclk;
                n++;
            end
            c("edges_before_abort", 32'(tg), 32'(10));
            rst = 1'b1;
            @(posedge clk);
            #1;
            c("abort_busy", 32'(busy), 32'(0));
            c("abort_done", 32'(done), 32'(0));
            c("abort_ss_n", 32'(ss_n), 32'(SS_OFF));
            c("abort_sclk", 32'(sclk), 32'(0));
            c("abort_mosi", 32'(mosi), 32'(0));
            c("abort_rx_data", 32'(rx_data), 32'(0));
            q.delete();
            @(negedge clk);
            rst = 1'b0;
            last_cpol = 1'b0;
            n = 0;
            repeat (2 * CD * (2 * DW + 2)) begin
                @(negedge clk);
                if (done) n++;
            end
            c("no_done_after_abort", 32'(n), 32'(0));

            issue(32'h6C39, 0, 2'd1, 32'h71E5, 0);
            n = 0;
            while (q.size() > 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            c("queue_drained", 32'(q.size()), 32'(0));
            fin = 1'b1;
        end
    end

    initial begin
        wait (gen_cfg[0].fin && gen_cfg[1].fin);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected both configs finished");
        $fatal(1, "watchdog expired");
    end

endmodule
